// File: rtl/sd2_to_bin_mod_pkg.sv
// Shared types for the redundant-binary to binary residue converter: the
// signed-digit encoding, the converter FSM states and the digit decode helper.
package sd2_to_bin_mod_pkg;

  // Raw code 2'b11 is not a member; it decodes as zero and is flagged as illegal.
  typedef enum logic [1:0] {
    SD2_ZER = 2'b00,
    SD2_POS = 2'b01,
    SD2_NEG = 2'b10
  } sd2_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    FIX,
    DONE
  } sd2c_state_t;

  // Returns {p,q}: p marks a +1 digit, q marks a -1 digit.
  function automatic logic [1:0] sd2_val(input sd2_t d);
    case (d)
      SD2_POS: return 2'b10;
      SD2_NEG: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/sd2_to_bin_mod_chunk_sub.sv
// W-digit slice of the P - Q subtraction with ripple borrow.
// Also flags any digit carrying the illegal raw code.
module sd2_chunk_sub
  import sd2_to_bin_mod_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [2*W-1:0] z,
  input  logic           bin,
  output logic [W-1:0]   d,
  output logic           bout,
  output logic           illegal
);

  always_comb begin
    logic       b;
    logic [1:0] pq;
    b       = bin;
    pq      = 2'b00;
    d       = '0;
    illegal = 1'b0;
    for (int i = 0; i < W; i++) begin
      pq      = sd2_val(sd2_t'(z[2*i +: 2]));
      illegal = illegal | (z[2*i +: 2] == 2'b11);
      d[i]    = pq[1] ^ pq[0] ^ b;
      b       = (~pq[1] & (pq[0] | b)) | (pq[0] & b);
    end
    bout = b;
  end

endmodule

// File: rtl/sd2_to_bin_mod.sv
// Converts an N-digit signed-digit value to a residue in [0,M): W digits per
// cycle of chunked subtraction, then one modular-correction cycle.
module sd2_to_bin_mod
  import sd2_to_bin_mod_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_z,
  input  logic [N-1:0]   in_m,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_q,
  output logic           out_neg,
  output logic           out_err
);

  localparam int NC = N / W;
  localparam int CW = (NC > 1) ? $clog2(NC) : 1;

  if (N % W != 0) begin : g_bad_w
    $error("sd2_to_bin_mod: N must be a multiple of W");
  end

  sd2c_state_t    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic           err_q, err_d;
  logic           in_ready_q, in_ready_d;
  logic [N-1:0]   out_q_q, out_q_d;
  logic           out_neg_q, out_neg_d;
  logic           out_err_q, out_err_d;
  logic [2*N-1:0] z_q, z_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   r_q, r_d;

  logic [W-1:0]   diff;
  logic           bout;
  logic           illegal;
  logic [N+W-1:0] r_tmp;

  logic signed [N+1:0] rs, ms, cs;
  logic                r_neg, c_bad;

  sd2_chunk_sub #(.W(W)) u_chunk (
    .z       (z_q[2*W-1:0]),
    .bin     (borrow_q),
    .d       (diff),
    .bout    (bout),
    .illegal (illegal)
  );

  // Final borrow is the sign of r; two extra bits keep r+M and r-M exact.
  always_comb begin
    rs    = $signed({borrow_q, borrow_q, r_q});
    ms    = $signed({2'b00, m_q});
    r_neg = rs < 0;
    if (r_neg)        cs = rs + ms;
    else if (rs >= ms) cs = rs - ms;
    else              cs = rs;
    c_bad = (cs < 0) || (cs >= ms);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    borrow_d  = borrow_q;
    err_d     = err_q;
    out_q_d   = out_q_q;
    out_neg_d = out_neg_q;
    out_err_d = out_err_q;
    z_d       = z_q;
    m_d       = m_q;
    r_d       = r_q;
    r_tmp     = {diff, r_q};
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          z_d      = in_z;
          m_d      = in_m;
          borrow_d = 1'b0;
          cnt_d    = '0;
          err_d    = 1'b0;
          state_d  = CONV;
        end
      end
      CONV: begin
        // Chunks arrive LSB first, so each new one enters at the top and shifts down.
        r_d      = r_tmp[N+W-1:W];
        z_d      = z_q >> (2 * W);
        borrow_d = bout;
        err_d    = err_q | illegal;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(NC - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        out_q_d   = cs[N-1:0];
        out_neg_d = r_neg;
        out_err_d = err_q | c_bad;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      out_q_q    <= '0;
      out_neg_q  <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      out_q_q    <= out_q_d;
      out_neg_q  <= out_neg_d;
      out_err_q  <= out_err_d;
    end
  end

  always_ff @(posedge clk) begin
    z_q <= z_d;
    m_q <= m_d;
    r_q <= r_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == DONE);
  assign out_q     = out_q_q;
  assign out_neg   = out_neg_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_sd2_to_bin_mod.sv
// Bench for sd2_to_bin_mod: directed cases, backpressure, mid-flight reset and
// randomized transactions against an integer-arithmetic reference model.
module tb_sd2_to_bin_mod;

  localparam int N = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [15:0]  in_z = '0;
  logic [7:0]   in_m = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   out_q;
  logic         out_neg;
  logic         out_err;

  int errs   = 0;
  int checks = 0;

  sd2_to_bin_mod #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_z      (in_z),
    .in_m      (in_m),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_neg   (out_neg),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: r = sum(d_i * 2^i) as an integer, then a single +/-M correction.
  task automatic model(input logic [15:0] z, input logic [7:0] m,
                       output logic [7:0] q, output logic neg, output logic err);
    int r, c;
    logic [1:0] d;
    r = 0; err = 1'b0; neg = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = z[2*i +: 2];
      if (d == 2'b01) r += (1 << i);
      else if (d == 2'b10) r -= (1 << i);
      else if (d == 2'b11) err = 1'b1;
    end
    if (r < 0) begin c = r + int'(m); neg = 1'b1; end
    else if (r >= int'(m)) c = r - int'(m);
    else c = r;
    if (c < 0 || c >= int'(m)) err = 1'b1;
    q = 8'(c);
  endtask

  task automatic send(input logic [15:0] z, input logic [7:0] m);
    int g = 0;
    while (!in_ready && g < 20) begin @(posedge clk); #1; g++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    in_z = z; in_m = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_m = 8'($urandom);
    in_z = 16'($urandom);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("ack_out_valid", out_valid, 0);
    chk("ack_in_ready", in_ready, 1);
  endtask

  task automatic txn(input string tag, input logic [15:0] z, input logic [7:0] m,
                     input logic [7:0] eq, input logic eneg, input logic eerr);
    int lat;
    send(z, m);
    wait_out(lat);
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_q"}, out_q, eq);
    chk({tag, "_neg"}, out_neg, eneg);
    chk({tag, "_err"}, out_err, eerr);
    ack();
  endtask

  initial begin
    int lat;
    logic [7:0]  q, m;
    logic        neg, err;
    logic [15:0] z;

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_q", out_q, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    txn("zero",  16'h0000, 8'd13, 8'd0,   1'b0, 1'b0);
    txn("r5",    16'h0061, 8'd13, 8'd5,   1'b0, 1'b0);
    txn("rm3",   16'h0021, 8'd13, 8'd10,  1'b1, 1'b0);
    txn("r16",   16'h0100, 8'd13, 8'd3,   1'b0, 1'b0);
    txn("r128",  16'h4000, 8'd13, 8'd115, 1'b0, 1'b1);

    // Backpressure: result held, input side blocked, stray in_valid ignored.
    send(16'h0061, 8'd13);
    wait_out(lat);
    chk("bp_latency", lat, 3);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0];
      in_z = 16'h0100;
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_q", out_q, 5);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    ack();
    repeat (4) begin @(posedge clk); #1; end
    chk("bp_no_latch", out_valid, 0);
    chk("bp_idle_ready", in_ready, 1);

    // Reset in CONV, after a transaction left nonzero outputs behind.
    txn("pre_rst", 16'h4000, 8'd13, 8'd115, 1'b0, 1'b1);
    send(16'h0061, 8'd13);
    #2; rst = 1'b0; #1;
    chk("midrst_q", out_q, 0);
    chk("midrst_err", out_err, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", in_ready, 1);
    txn("after_rst", 16'h0061, 8'd13, 8'd5, 1'b0, 1'b0);
    txn("illegal",   16'h0003, 8'd13, 8'd0, 1'b0, 1'b1);

    for (int t = 0; t < 150; t++) begin
      m = 8'($urandom_range(255, 1));
      for (int i = 0; i < N; i++) begin
        int sel = $urandom_range(15, 0);
        z[2*i +: 2] = (sel < 5) ? 2'b00 : (sel < 10) ? 2'b01 : (sel < 15) ? 2'b10 : 2'b11;
      end
      model(z, m, q, neg, err);
      txn("rand", z, m, q, neg, err);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
